// File: rtl/pcie_phy_tx_framer.sv
// PCIe PHY transmit framer: buffers 268-bit DLL frames and serialises them as STP / 9 payload words / END.
// Optional idle-word insertion while no frame is in flight: define PCIE_PHY_TX_IDLE_INSERT_EN.
module pcie_phy_tx_framer #(
  parameter int         DEPTH   = 2,
  parameter logic [7:0] STP_SYM = 8'hFB,
  parameter logic [7:0] END_SYM = 8'hFD
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tlp_valid_i,
  input  logic [267:0] tlp_i,
  output logic         tlp_ready_o,
  output logic         data_valid_o,
  output logic [31:0]  data_o,
  output logic [3:0]   data_k_o,
  input  logic         data_ready_i,
  output logic         overflow_o,
  output logic [15:0]  frame_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

`ifdef PCIE_PHY_TX_IDLE_INSERT_EN
  localparam logic        IDLE_VALID = 1'b1;
  localparam logic [31:0] IDLE_DATA  = 32'h7C7C7C7C;
  localparam logic [3:0]  IDLE_K     = 4'b1111;
`else
  localparam logic        IDLE_VALID = 1'b0;
  localparam logic [31:0] IDLE_DATA  = 32'h0000_0000;
  localparam logic [3:0]  IDLE_K     = 4'b0000;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_END     = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [267:0]   mem_q [DEPTH];
  logic [267:0]   mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [287:0]   sr_q, sr_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           overflow_q, overflow_d;
  logic           tlp_ready_q, tlp_ready_d;
  logic           data_valid_q, data_valid_d;
  logic [31:0]    data_q, data_d;
  logic [3:0]     data_k_q, data_k_d;

  logic full_s, empty_s, accept_s, pop_s, wr_en_s;

  // Next-state, FIFO bookkeeping and registered-output computation
  always_comb begin
    full_s      = (count_q == FULL_CNT);
    empty_s     = (count_q == {(AW + 1){1'b0}});
    accept_s    = data_valid_q && data_ready_i;
    pop_s       = 1'b0;
    state_d     = state_q;
    sr_d        = sr_q;
    wcnt_d      = wcnt_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // A driven idle word must be accepted before a frame may start.
        if (!empty_s && (!data_valid_q || data_ready_i)) begin
          pop_s   = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (accept_s) begin
          state_d = ST_PAYLOAD;
          wcnt_d  = 4'd0;
        end else begin
          state_d = ST_START;
        end
      end
      ST_PAYLOAD: begin
        if (accept_s && (wcnt_q == 4'd8)) begin
          state_d = ST_END;
        end else if (accept_s) begin
          wcnt_d = wcnt_q + 4'd1;
          sr_d   = {sr_q[255:0], 32'h0000_0000};
        end else begin
          state_d = ST_PAYLOAD;
        end
      end
      ST_END: begin
        if (accept_s) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_END;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop_s) begin
      sr_d = {20'h0_0000, mem_q[rd_ptr_q]};
    end else begin
      sr_d = sr_d;
    end

    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    wr_en_s    = tlp_valid_i && (!full_s || pop_s);
    overflow_d = overflow_q || (tlp_valid_i && full_s && !pop_s);

    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = tlp_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    tlp_ready_d = (count_d != FULL_CNT);

    case (state_d)
      ST_IDLE: begin
        data_valid_d = IDLE_VALID;
        data_d       = IDLE_DATA;
        data_k_d     = IDLE_K;
      end
      ST_START: begin
        data_valid_d = 1'b1;
        data_d       = {STP_SYM, 24'h00_0000};
        data_k_d     = 4'b1000;
      end
      ST_PAYLOAD: begin
        data_valid_d = 1'b1;
        data_d       = sr_d[287:256];
        data_k_d     = 4'b0000;
      end
      ST_END: begin
        data_valid_d = 1'b1;
        data_d       = {24'h00_0000, END_SYM};
        data_k_d     = 4'b0001;
      end
      default: begin
        data_valid_d = 1'b0;
        data_d       = 32'h0000_0000;
        data_k_d     = 4'b0000;
      end
    endcase
  end

  // State, FIFO and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 268'd0;
      end
      wr_ptr_q     <= {AW{1'b0}};
      rd_ptr_q     <= {AW{1'b0}};
      count_q      <= {(AW + 1){1'b0}};
      sr_q         <= 288'd0;
      wcnt_q       <= 4'd0;
      frame_cnt_q  <= 16'd0;
      overflow_q   <= 1'b0;
      tlp_ready_q  <= 1'b1;
      data_valid_q <= 1'b0;
      data_q       <= 32'h0000_0000;
      data_k_q     <= 4'b0000;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      sr_q         <= sr_d;
      wcnt_q       <= wcnt_d;
      frame_cnt_q  <= frame_cnt_d;
      overflow_q   <= overflow_d;
      tlp_ready_q  <= tlp_ready_d;
      data_valid_q <= data_valid_d;
      data_q       <= data_d;
      data_k_q     <= data_k_d;
    end
  end

  assign tlp_ready_o  = tlp_ready_q;
  assign data_valid_o = data_valid_q;
  assign data_o       = data_q;
  assign data_k_o     = data_k_q;
  assign overflow_o   = overflow_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_pcie_phy_tx_framer.sv
// Scoreboard bench for pcie_phy_tx_framer; builds with or without PCIE_PHY_TX_IDLE_INSERT_EN.
module tb_pcie_phy_tx_framer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tlp_valid_i;
  logic [267:0] tlp_i;
  logic         tlp_ready_o;
  logic         data_valid_o;
  logic [31:0]  data_o;
  logic [3:0]   data_k_o;
  logic         data_ready_i;
  logic         overflow_o;
  logic [15:0]  frame_cnt_o;

  int errors = 0;
  int checks = 0;
  logic [35:0] sb_q[$];
  logic [35:0] mon_exp;

  logic        exp_idle_valid;
  logic [31:0] exp_idle_data, exp_stall_data;
  logic [3:0]  exp_idle_k, exp_stall_k;

  localparam logic [223:0] TLP_A = 224'h123456789ABCDEF0_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0_01234567;
  localparam logic [223:0] TLP_B = 224'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3;

  always #5 clk = ~clk;

  pcie_phy_tx_framer #(.DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tlp_valid_i  (tlp_valid_i),
    .tlp_i        (tlp_i),
    .tlp_ready_o  (tlp_ready_o),
    .data_valid_o (data_valid_o),
    .data_o       (data_o),
    .data_k_o     (data_k_o),
    .data_ready_i (data_ready_i),
    .overflow_o   (overflow_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  // Scoreboard: every accepted non-idle word must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && data_valid_o && data_ready_i && data_k_o !== 4'b1111) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got %h k=%b, expected no word", data_o, data_k_o);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({data_k_o, data_o} !== mon_exp) begin
          errors++;
          $display("FAIL sb_word: got %h k=%b, expected %h k=%b",
                   data_o, data_k_o, mon_exp[31:0], mon_exp[35:32]);
        end
      end
    end
  end

  task automatic push_frame(input logic [11:0] seq, input logic [223:0] tlp,
                            input logic [31:0] crc, input bit expect_out);
    logic [287:0] pl;
    pl = {20'h0_0000, seq, tlp, crc};
    if (expect_out) begin
      sb_q.push_back({4'b1000, 32'hFB00_0000});
      for (int w = 0; w < 9; w++) sb_q.push_back({4'b0000, pl[287 - 32*w -: 32]});
      sb_q.push_back({4'b0001, 32'h0000_00FD});
    end
    tlp_i       = {seq, tlp, crc};
    tlp_valid_i = 1'b1;
    @(posedge clk); #1;
    tlp_valid_i = 1'b0;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n        = 1'b0;
    tlp_valid_i  = 1'b0;
    data_ready_i = rdy;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) break;
    end
    @(posedge clk); #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words still pending, expected 0", name, sb_q.size());
    end
  endtask

  task automatic wait_word(input logic [31:0] w, output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (data_valid_o && data_k_o == 4'b0000 && data_o === w) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tlp_valid_i = 1'b0; data_ready_i = 1'b0; tlp_i = '0;
    #12;
    checks += 6;
    if (data_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", data_valid_o); end
    if (data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h, expected 0", data_o); end
    if (data_k_o !== 4'b0) begin errors++; $display("FAIL rst_k: got %b, expected 0000", data_k_o); end
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, expected 0", overflow_o); end
    if (frame_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %0d, expected 0", frame_cnt_o); end
    if (tlp_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, expected 1", tlp_ready_o); end
  endtask

  task automatic test_single_frame;
    do_reset(1'b1);
    push_frame(12'h005, TLP_A, 32'hDEADBEEF, 1'b1);
    checks++;
    if (data_valid_o !== exp_idle_valid) begin
      errors++; $display("FAIL single_early: valid %b, expected %b", data_valid_o, exp_idle_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({data_valid_o, data_k_o, data_o} !== {1'b1, 4'b1000, 32'hFB00_0000}) begin
      errors++; $display("FAIL single_start: got v=%b k=%b %h, expected v=1 k=1000 fb000000",
                         data_valid_o, data_k_o, data_o);
    end
    drain("single");
    checks++;
    if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL single_cnt: got %0d, expected 1", frame_cnt_o); end
  endtask

  task automatic test_back_to_back;
    int n;
    do_reset(1'b1);
    push_frame(12'h101, TLP_A, 32'h11112222, 1'b1);
    push_frame(12'h102, TLP_B, 32'h33334444, 1'b1);
    n = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (data_valid_o) n++;
    end
    checks++;
    if (n != 22) begin errors++; $display("FAIL b2b_gapless: got %0d valid words, expected 22", n); end
    @(negedge clk);
    checks++;
    if (data_valid_o !== exp_idle_valid) begin
      errors++; $display("FAIL b2b_after: valid %b, expected %b", data_valid_o, exp_idle_valid);
    end
    drain("b2b");
    checks++;
    if (frame_cnt_o !== 16'd2) begin errors++; $display("FAIL b2b_cnt: got %0d, expected 2", frame_cnt_o); end
  endtask

  task automatic test_backpressure;
    logic [287:0] pl;
    bit found;
    do_reset(1'b1);
    pl = {20'h0_0000, 12'hABC, TLP_B, 32'h0BADF00D};
    push_frame(12'hABC, TLP_B, 32'h0BADF00D, 1'b1);
    wait_word(pl[287 - 96 -: 32], found);
    checks++;
    if (!found) begin errors++; $display("FAIL bp_find: word3 not seen, expected %h", pl[287 - 96 -: 32]); end
    data_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({data_valid_o, data_k_o, data_o} !== {1'b1, 4'b0000, pl[287 - 96 -: 32]}) begin
        errors++; $display("FAIL bp_hold: got v=%b k=%b %h, expected v=1 k=0000 %h",
                           data_valid_o, data_k_o, data_o, pl[287 - 96 -: 32]);
      end
    end
    @(posedge clk); #1 data_ready_i = 1'b1;
    drain("bp");
    checks++;
    if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL bp_cnt: got %0d, expected 1", frame_cnt_o); end
  endtask

  task automatic test_overflow;
    do_reset(1'b1);
    push_frame(12'h001, TLP_A, 32'hA0000001, 1'b1);
    push_frame(12'h002, TLP_B, 32'hA0000002, 1'b1);
    data_ready_i = 1'b0;
    push_frame(12'h003, TLP_A, 32'hA0000003, 1'b1);
    push_frame(12'h004, TLP_B, 32'hA0000004, 1'b0);
    checks += 3;
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow_o); end
    if (tlp_ready_o !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b, expected 0", tlp_ready_o); end
    if ({data_valid_o, data_o} !== {1'b1, 32'hFB00_0000}) begin
      errors++; $display("FAIL ovf_start: got v=%b %h, expected v=1 fb000000", data_valid_o, data_o);
    end
    data_ready_i = 1'b1;
    drain("ovf");
    repeat (15) @(negedge clk);
    checks += 2;
    if (frame_cnt_o !== 16'd3) begin errors++; $display("FAIL ovf_cnt: got %0d, expected 3", frame_cnt_o); end
    if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", overflow_o); end
  endtask

  task automatic test_full_pop;
    bit found;
    do_reset(1'b1);
    push_frame(12'h011, TLP_A, 32'hC0000001, 1'b1);
    push_frame(12'h012, TLP_B, 32'hC0000002, 1'b1);
    push_frame(12'h013, TLP_A, 32'hC0000003, 1'b1);
    checks++;
    if (tlp_ready_o !== 1'b0) begin errors++; $display("FAIL fp_full: ready %b, expected 0", tlp_ready_o); end
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (data_valid_o && data_k_o == 4'b0001) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL fp_end: END not seen, expected 000000fd"); end
    push_frame(12'h014, TLP_B, 32'hC0000004, 1'b1);
    checks += 2;
    if (overflow_o !== 1'b0) begin errors++; $display("FAIL fp_ovf: got %b, expected 0", overflow_o); end
    if (tlp_ready_o !== 1'b0) begin errors++; $display("FAIL fp_refull: ready %b, expected 0", tlp_ready_o); end
    drain("fp");
    checks++;
    if (frame_cnt_o !== 16'd4) begin errors++; $display("FAIL fp_cnt: got %0d, expected 4", frame_cnt_o); end
  endtask

  task automatic test_reset_mid_frame;
    logic [287:0] pl;
    bit found;
    do_reset(1'b1);
    pl = {20'h0_0000, 12'h777, TLP_A, 32'h55AA55AA};
    push_frame(12'h777, TLP_A, 32'h55AA55AA, 1'b1);
    wait_word(pl[287 - 160 -: 32], found);
    checks++;
    if (!found) begin errors++; $display("FAIL rm_find: word5 not seen, expected %h", pl[287 - 160 -: 32]); end
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    checks++;
    if ({data_valid_o, data_k_o, data_o} !== 37'd0) begin
      errors++; $display("FAIL rm_abort: got v=%b k=%b %h, expected all 0", data_valid_o, data_k_o, data_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks += 2;
    if (data_valid_o !== exp_idle_valid) begin
      errors++; $display("FAIL rm_valid: got %b, expected %b", data_valid_o, exp_idle_valid);
    end
    if (frame_cnt_o !== 16'd0) begin errors++; $display("FAIL rm_cnt: got %0d, expected 0", frame_cnt_o); end
  endtask

  task automatic test_idle;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({data_valid_o, data_k_o, data_o} !== {exp_idle_valid, exp_idle_k, exp_idle_data}) begin
      errors++; $display("FAIL idle_word: got v=%b k=%b %h, expected v=%b k=%b %h", data_valid_o, data_k_o,
                         data_o, exp_idle_valid, exp_idle_k, exp_idle_data);
    end
    push_frame(12'h0EE, TLP_B, 32'h12121212, 1'b1);
    repeat (3) @(negedge clk);
    checks++;
    if ({data_valid_o, data_k_o, data_o} !== {1'b1, exp_stall_k, exp_stall_data}) begin
      errors++; $display("FAIL idle_stall: got v=%b k=%b %h, expected v=1 k=%b %h", data_valid_o, data_k_o,
                         data_o, exp_stall_k, exp_stall_data);
    end
    @(posedge clk); #1 data_ready_i = 1'b1;
    drain("idle");
    checks++;
    if (frame_cnt_o !== 16'd1) begin errors++; $display("FAIL idle_cnt: got %0d, expected 1", frame_cnt_o); end
  endtask

  initial begin
`ifdef PCIE_PHY_TX_IDLE_INSERT_EN
    exp_idle_valid = 1'b1; exp_idle_data = 32'h7C7C7C7C; exp_idle_k = 4'b1111;
    exp_stall_data = 32'h7C7C7C7C; exp_stall_k = 4'b1111;
`else
    exp_idle_valid = 1'b0; exp_idle_data = 32'h0; exp_idle_k = 4'b0000;
    exp_stall_data = 32'hFB00_0000; exp_stall_k = 4'b1000;
`endif
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_reset_mid_frame();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
